// File: rtl/counter_if.sv
// Bus between the elevator controller FSM (master) and the interval timer (slave).
// The hold line exists only when COUNTER_PAUSE_EN is defined.
interface counter_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] m_time;
`ifdef COUNTER_PAUSE_EN
    logic             hold;
`endif
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] remaining;

`ifdef COUNTER_PAUSE_EN
    modport master (output start, output m_time, output hold,
                    input done, input busy, input remaining);
    modport slave  (input start, input m_time, input hold,
                    output done, output busy, output remaining);
`else
    modport master (output start, output m_time,
                    input done, input busy, input remaining);
    modport slave  (input start, input m_time,
                    output done, output busy, output remaining);
`endif
endinterface

// File: rtl/counter.sv
// Programmable down-counting interval timer with a TICK_DIV-cycle prescaler.
// Optional pause input (bus.hold) is compiled in when COUNTER_PAUSE_EN is defined.
module counter #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 1
) (
    input  logic     clk,
    input  logic     rst,
    counter_if.slave bus
);
    localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [PW-1:0]    prescaler_q, prescaler_d;
    logic             run_en;
    logic             tick;

`ifdef COUNTER_PAUSE_EN
    assign run_en = ~bus.hold;
`else
    assign run_en = 1'b1;
`endif

    assign tick = (prescaler_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        prescaler_d = prescaler_q;
        case (state_q)
            IDLE: begin
                remaining_d = '0;
                prescaler_d = '0;
                if (bus.start) begin
                    if (bus.m_time != '0) begin
                        remaining_d = bus.m_time;
                        state_d     = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // An abort wins over a final tick landing on the same edge.
                if (!bus.start) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                    prescaler_d = '0;
                end else if (run_en) begin
                    if (tick) begin
                        prescaler_d = '0;
                        if (remaining_q > WIDTH'(1)) begin
                            remaining_d = remaining_q - WIDTH'(1);
                        end else begin
                            remaining_d = '0;
                            state_d     = DONE;
                        end
                    end else begin
                        prescaler_d = prescaler_q + PW'(1);
                    end
                end
            end
            DONE: begin
                remaining_d = '0;
                prescaler_d = '0;
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
                prescaler_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            prescaler_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            prescaler_q <= prescaler_d;
        end
    end

    // Outputs come straight from registers, so start = ~done cannot form a loop.
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_counter.sv
// Testbench for counter: two instances (TICK_DIV=1 and TICK_DIV=4) checked against
// an arithmetic model of the interval (remaining = m_time - elapsed/TICK_DIV).
module tb_counter;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_man;
    logic             free_run;
    logic [WIDTH-1:0] m_time_tb;
`ifdef COUNTER_PAUSE_EN
    logic             hold_tb;
`endif

    int n_cmp = 0;
    int n_err = 0;

    counter_if #(.WIDTH(WIDTH)) bus1 ();
    counter_if #(.WIDTH(WIDTH)) bus4 ();

    assign bus1.start  = free_run ? ~bus1.done : start_man;
    assign bus1.m_time = m_time_tb;
    assign bus4.start  = start_man;
    assign bus4.m_time = m_time_tb;
`ifdef COUNTER_PAUSE_EN
    assign bus1.hold = hold_tb;
    assign bus4.hold = hold_tb;
`endif

    counter #(.WIDTH(WIDTH), .TICK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    counter #(.WIDTH(WIDTH), .TICK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    always #5 clk = ~clk;

    // Expected outputs n edges after the load edge, with start held the whole time.
    function automatic void model(input int mt, input int div, input int n,
                                  output logic eb, output logic ed, output logic [WIDTH-1:0] er);
        if (mt == 0 || n >= mt * div) begin
            eb = 1'b0;
            ed = 1'b1;
            er = '0;
        end else begin
            eb = 1'b1;
            ed = 1'b0;
            er = WIDTH'(mt - n / div);
        end
    endfunction

    task automatic test_reset();
        logic eb, ed;
        logic [WIDTH-1:0] er;
        rst = 1'b1;
        start_man = 1'b0;
        free_run = 1'b0;
        m_time_tb = 8'd10;
`ifdef COUNTER_PAUSE_EN
        hold_tb = 1'b0;
`endif
        #2;
        n_cmp += 3;
        if (bus1.done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got %b want 0", bus1.done); end
        if (bus1.busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", bus1.busy); end
        if (bus1.remaining !== 8'd0) begin n_err++; $display("[TB] FAIL reset_rem got %0d want 0", bus1.remaining); end
        @(negedge clk);
        rst = 1'b0;
        start_man = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (bus1.done !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_done got %b want 0", bus1.done); end
        if (bus1.busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy got %b want 0", bus1.busy); end
        if (bus1.remaining !== 8'd0) begin n_err++; $display("[TB] FAIL midrst_rem got %0d want 0", bus1.remaining); end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            model(10, 1, n, eb, ed, er);
            n_cmp += 3;
            if (bus1.busy !== eb) begin n_err++; $display("[TB] FAIL rerun_busy n=%0d got %b want %b", n, bus1.busy, eb); end
            if (bus1.done !== ed) begin n_err++; $display("[TB] FAIL rerun_done n=%0d got %b want %b", n, bus1.done, ed); end
            if (bus1.remaining !== er) begin n_err++; $display("[TB] FAIL rerun_rem n=%0d got %0d want %0d", n, bus1.remaining, er); end
        end
        start_man = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic eb, ed;
        logic [WIDTH-1:0] er;
        m_time_tb = 8'd10;
        start_man = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            model(10, 1, n, eb, ed, er);
            n_cmp += 3;
            if (bus1.busy !== eb) begin n_err++; $display("[TB] FAIL basic_busy n=%0d got %b want %b", n, bus1.busy, eb); end
            if (bus1.done !== ed) begin n_err++; $display("[TB] FAIL basic_done n=%0d got %b want %b", n, bus1.done, ed); end
            if (bus1.remaining !== er) begin n_err++; $display("[TB] FAIL basic_rem n=%0d got %0d want %0d", n, bus1.remaining, er); end
        end
        start_man = 1'b0;
        @(posedge clk); #1;
        n_cmp += 2;
        if (bus1.done !== 1'b0) begin n_err++; $display("[TB] FAIL basic_ack_done got %b want 0", bus1.done); end
        if (bus1.busy !== 1'b0) begin n_err++; $display("[TB] FAIL basic_ack_busy got %b want 0", bus1.busy); end
    endtask

    task automatic test_zero_length();
        m_time_tb = 8'd0;
        start_man = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            n_cmp += 4;
            if (bus1.done !== 1'b1) begin n_err++; $display("[TB] FAIL zero_done1 n=%0d got %b want 1", n, bus1.done); end
            if (bus1.busy !== 1'b0) begin n_err++; $display("[TB] FAIL zero_busy1 n=%0d got %b want 0", n, bus1.busy); end
            if (bus4.done !== 1'b1) begin n_err++; $display("[TB] FAIL zero_done4 n=%0d got %b want 1", n, bus4.done); end
            if (bus4.busy !== 1'b0) begin n_err++; $display("[TB] FAIL zero_busy4 n=%0d got %b want 0", n, bus4.busy); end
        end
        start_man = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        // Drop start after 5 cycles, then again one edge before the final tick.
        int drop_n [2] = '{4, 8};
        for (int t = 0; t < 2; t++) begin
            m_time_tb = 8'd10;
            start_man = 1'b1;
            repeat (drop_n[t] + 1) @(posedge clk);
            #1;
            n_cmp += 1;
            if (bus1.remaining !== 8'(10 - drop_n[t])) begin
                n_err++; $display("[TB] FAIL abort_pre_rem got %0d want %0d", bus1.remaining, 10 - drop_n[t]);
            end
            start_man = 1'b0;
            for (int n = 0; n < 3; n++) begin
                @(posedge clk); #1;
                n_cmp += 4;
                if (bus1.done !== 1'b0) begin n_err++; $display("[TB] FAIL abort_done n=%0d got %b want 0", n, bus1.done); end
                if (bus1.busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy n=%0d got %b want 0", n, bus1.busy); end
                if (bus1.remaining !== 8'd0) begin n_err++; $display("[TB] FAIL abort_rem n=%0d got %0d want 0", n, bus1.remaining); end
                if (bus4.busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy4 n=%0d got %b want 0", n, bus4.busy); end
            end
        end
    endtask

    task automatic test_free_run();
        int pulses = 0;
        logic ed, eb;
        m_time_tb = 8'd10;
        free_run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            ed = (i % 12 == 10);
            eb = (i % 12 < 10);
            if (bus1.done === 1'b1) pulses++;
            n_cmp += 2;
            if (bus1.done !== ed) begin n_err++; $display("[TB] FAIL freerun_done i=%0d got %b want %b", i, bus1.done, ed); end
            if (bus1.busy !== eb) begin n_err++; $display("[TB] FAIL freerun_busy i=%0d got %b want %b", i, bus1.busy, eb); end
        end
        n_cmp += 1;
        if (pulses != 5) begin n_err++; $display("[TB] FAIL freerun_pulses got %0d want 5", pulses); end
        free_run = 1'b0;
        start_man = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_prescaler();
        logic eb, ed;
        logic [WIDTH-1:0] er;
        m_time_tb = 8'd3;
        start_man = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            model(3, 4, n, eb, ed, er);
            n_cmp += 3;
            if (bus4.busy !== eb) begin n_err++; $display("[TB] FAIL presc_busy n=%0d got %b want %b", n, bus4.busy, eb); end
            if (bus4.done !== ed) begin n_err++; $display("[TB] FAIL presc_done n=%0d got %b want %b", n, bus4.done, ed); end
            if (bus4.remaining !== er) begin n_err++; $display("[TB] FAIL presc_rem n=%0d got %0d want %0d", n, bus4.remaining, er); end
        end
        start_man = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef COUNTER_PAUSE_EN
    task automatic test_pause();
        logic eb, ed;
        logic [WIDTH-1:0] er;
        int eff;
        m_time_tb = 8'd3;
        start_man = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            // Hold covers the five edges after sample n=5.
            eff = n - ((n > 10) ? 5 : ((n > 5) ? n - 5 : 0));
            model(3, 4, eff, eb, ed, er);
            n_cmp += 4;
            if (bus4.busy !== eb) begin n_err++; $display("[TB] FAIL pause_busy n=%0d got %b want %b", n, bus4.busy, eb); end
            if (bus4.done !== ed) begin n_err++; $display("[TB] FAIL pause_done n=%0d got %b want %b", n, bus4.done, ed); end
            if (bus4.remaining !== er) begin n_err++; $display("[TB] FAIL pause_rem n=%0d got %0d want %0d", n, bus4.remaining, er); end
            if (bus1.done !== (n >= 3)) begin n_err++; $display("[TB] FAIL pause_done1 n=%0d got %b want %b", n, bus1.done, n >= 3); end
            if (n == 5) hold_tb = 1'b1;
            if (n == 10) hold_tb = 1'b0;
        end
        start_man = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_random();
        logic eb, ed;
        logic [WIDTH-1:0] er;
        int mt, stop_n;
        for (int t = 0; t < 20; t++) begin
            mt = int'($urandom_range(0, 12));
            stop_n = int'($urandom_range(0, mt * 4 + 6));
            m_time_tb = 8'(mt);
            start_man = 1'b1;
            for (int n = 0; n <= stop_n; n++) begin
                @(posedge clk); #1;
                if (n == 0) m_time_tb = 8'($urandom);
                model(mt, 1, n, eb, ed, er);
                n_cmp += 3;
                if (bus1.busy !== eb) begin n_err++; $display("[TB] FAIL rand_busy1 t=%0d n=%0d got %b want %b", t, n, bus1.busy, eb); end
                if (bus1.done !== ed) begin n_err++; $display("[TB] FAIL rand_done1 t=%0d n=%0d got %b want %b", t, n, bus1.done, ed); end
                if (bus1.remaining !== er) begin n_err++; $display("[TB] FAIL rand_rem1 t=%0d n=%0d got %0d want %0d", t, n, bus1.remaining, er); end
                model(mt, 4, n, eb, ed, er);
                n_cmp += 3;
                if (bus4.busy !== eb) begin n_err++; $display("[TB] FAIL rand_busy4 t=%0d n=%0d got %b want %b", t, n, bus4.busy, eb); end
                if (bus4.done !== ed) begin n_err++; $display("[TB] FAIL rand_done4 t=%0d n=%0d got %b want %b", t, n, bus4.done, ed); end
                if (bus4.remaining !== er) begin n_err++; $display("[TB] FAIL rand_rem4 t=%0d n=%0d got %0d want %0d", t, n, bus4.remaining, er); end
            end
            start_man = 1'b0;
            @(posedge clk); #1;
            n_cmp += 4;
            if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin n_err++; $display("[TB] FAIL rand_idle1 t=%0d got done=%b busy=%b want 0 0", t, bus1.done, bus1.busy); end
            if (bus1.remaining !== 8'd0) begin n_err++; $display("[TB] FAIL rand_idlerem1 t=%0d got %0d want 0", t, bus1.remaining); end
            if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin n_err++; $display("[TB] FAIL rand_idle4 t=%0d got done=%b busy=%b want 0 0", t, bus4.done, bus4.busy); end
            if (bus4.remaining !== 8'd0) begin n_err++; $display("[TB] FAIL rand_idlerem4 t=%0d got %0d want 0", t, bus4.remaining); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_abort();
        test_free_run();
        test_prescaler();
`ifdef COUNTER_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got timeout want completion");
        $fatal(1, "[TB] timeout");
    end
endmodule
